// File: rtl/detector_jogada.sv
// Debounced play detector: synchronizes four push-buttons and emits one
// pulse per debounced press (valid one-hot play or rejected multi-press).
module detector_jogada #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] botoes,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       jogada_invalida,
  output logic       db_tem_jogada,
  output logic [3:0] db_estado
);

  typedef enum logic [1:0] {
    ESPERA      = 2'd0,
    FILTRA      = 2'd1,
    PRESSIONADO = 2'd2,
    SOLTA       = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] amostra_q, amostra_d;
  logic [3:0] jogada_q, jogada_d;
  logic       feita_q, feita_d;
  logic       invalida_q, invalida_d;
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] s;
  logic       amostra_onehot;

  assign sync1_d        = botoes;
  assign sync2_d        = sync1_q;
  assign s              = sync2_q;
  assign amostra_onehot = (amostra_q != 4'd0) && ((amostra_q & (amostra_q - 4'd1)) == 4'd0);

  // State register (synchronizer stages and all registered outputs included)
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ESPERA;
      cnt_q      <= 8'd0;
      amostra_q  <= 4'd0;
      jogada_q   <= 4'd0;
      feita_q    <= 1'b0;
      invalida_q <= 1'b0;
      sync1_q    <= 4'd0;
      sync2_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      amostra_q  <= amostra_d;
      jogada_q   <= jogada_d;
      feita_q    <= feita_d;
      invalida_q <= invalida_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
    end
  end

  // Next-state logic; pulses are decided on the FILTRA->PRESSIONADO edge
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    amostra_d  = amostra_q;
    jogada_d   = jogada_q;
    feita_d    = 1'b0;
    invalida_d = 1'b0;
    case (state_q)
      ESPERA: begin
        if (enable && (s != 4'd0)) begin
          state_d   = FILTRA;
          amostra_d = s;
          cnt_d     = 8'd0;
        end
      end
      FILTRA: begin
        if ((s == 4'd0) || !enable) begin
          state_d = ESPERA;
        end else if (s != amostra_q) begin
          amostra_d = s;
          cnt_d     = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSIONADO;
          if (amostra_onehot) begin
            jogada_d = amostra_q;
            feita_d  = 1'b1;
          end else begin
            invalida_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PRESSIONADO: begin
        if (s == 4'd0) begin
          state_d = SOLTA;
          cnt_d   = 8'd0;
        end
      end
      SOLTA: begin
        // enable is deliberately ignored here so a release always completes
        if (s != 4'd0) begin
          state_d = PRESSIONADO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ESPERA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ESPERA;
    endcase
  end

  always_comb begin
    jogada          = jogada_q;
    jogada_feita    = feita_q;
    jogada_invalida = invalida_q;
    db_tem_jogada   = |s;
    db_estado       = {2'b00, state_q};
  end

endmodule

// File: doc/detector_jogada.md
DETECTOR_JOGADA -- requirements
Module: detector_jogada

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: number of consecutive identical synchronized samples required to accept a press or a release; legal range 2..255.
REQ-002 clock  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset; synchronous and active-high.
REQ-004 enable  input  1  high = game FSM is accepting plays; low = new presses ignored.
REQ-005 botoes  input  4  raw asynchronous push-button levels, one bit per button.
REQ-006 jogada  output  4  last accepted one-hot play code; registered.
REQ-007 jogada_feita  output  1  one-cycle pulse, high when a valid play is accepted.
REQ-008 jogada_invalida  output  1  one-cycle pulse, high when a stable multi-button press is rejected.
REQ-009 db_tem_jogada  output  1  high when the synchronized button vector is non-zero.
REQ-010 db_estado  output  4  current FSM state code.

Function
REQ-011 botoes SHALL pass through a 2-flop synchronizer; the synchronized vector s SHALL be the only value used by the FSM.
REQ-012 The FSM SHALL have four states: ESPERA=0, FILTRA=1, PRESSIONADO=2, SOLTA=3; db_estado = state code, zero-extended.
REQ-013 ESPERA: if enable=1 and s!=0, go to FILTRA, load amostra<=s, cnt<=0; otherwise stay.
REQ-014 FILTRA: if s==0 or enable=0, go to ESPERA with no pulse.
REQ-015 FILTRA: if s!=0 and s!=amostra, reload amostra<=s and set cnt<=0.
REQ-016 FILTRA: if s==amostra and cnt<DEBOUNCE_CYCLES-1, cnt<=cnt+1.
REQ-017 FILTRA: if s==amostra and cnt==DEBOUNCE_CYCLES-1, go to PRESSIONADO.
REQ-018 On the FILTRA->PRESSIONADO transition, if amostra is one-hot, jogada<=amostra and jogada_feita=1 for exactly the next cycle.
REQ-019 On the FILTRA->PRESSIONADO transition, if amostra is not one-hot, jogada is unchanged and jogada_invalida=1 for exactly the next cycle.
REQ-020 PRESSIONADO: stay while s!=0; no further pulses regardless of hold length; on s==0 go to SOLTA with cnt<=0.
REQ-021 SOLTA: if s!=0, return to PRESSIONADO with no pulse (release bounce).
REQ-022 SOLTA: else cnt<=cnt+1; at cnt==DEBOUNCE_CYCLES-1 go to ESPERA.
REQ-023 Latency: with botoes stable and non-zero from before edge E0 and enable=1:
- s valid after E1;
- FILTRA entered at E2;
- pulse high during the cycle following E(2+DEBOUNCE_CYCLES), i.e. after E6 for the default.
REQ-024 jogada_feita and jogada_invalida SHALL never be high in the same cycle; at most one pulse per press-release cycle.
REQ-025 jogada SHALL hold its value until the next accepted valid play or reset.
REQ-026 enable dropping in PRESSIONADO or SOLTA SHALL NOT alter those states; the release SHALL still be debounced.
REQ-027 db_tem_jogada SHALL equal the OR of s, combinational from the synchronizer output.
REQ-028 cnt width SHALL be 8 bits; cnt never wraps because every state exits at DEBOUNCE_CYCLES-1.

Reset
REQ-029 When reset=1 at a rising edge, the block SHALL set state=ESPERA, cnt=0, amostra=0, both synchronizer stages=0, jogada=0000, jogada_feita=0 and jogada_invalida=0.
REQ-030 Reset SHALL take priority over all other inputs.
REQ-031 Reset asserted mid-FILTRA SHALL suppress any pending pulse.

Verification
REQ-032 reset=1 one cycle -> jogada=0000, jogada_feita=0, jogada_invalida=0, db_estado=0, db_tem_jogada=0.
REQ-033 enable=1, botoes=0100 for 10 cycles then 0000 -> single jogada_feita pulse after E6; jogada=0100; db_estado returns to 0 within 2+4 cycles of release.
REQ-034 botoes=0010 for 2 cycles then 0000 -> no pulse; jogada unchanged; db_estado back to 0.
REQ-035 botoes=0011 for 10 cycles -> one jogada_invalida pulse and no jogada_feita; jogada keeps its prior value (0100).
REQ-036 Hold 1000 to accept, release 2 cycles, re-press 1000 for 5 cycles, full release, then 0001 for 10 cycles -> exactly two jogada_feita pulses total, final jogada=0001.
REQ-037 Two cases:
- enable=0 with botoes=0001 for 10 cycles -> no pulse, state stays 0.
- reset during FILTRA -> no pulse, db_estado=0.
